btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Multi-channel push-button front end: per-channel 2-FF synchroniser, counter-based debounce, press/release edge pulses and hold-to-repeat pulses.
- Sits between the raw board keys and the game control FSM.
- Successor to the single-bit fixed-width debounce and edge helpers: parametrised channel count, debounce length, input polarity, and auto-repeat.

Parameters:
- N_CH, 4, number of independent button channels.
- DEB_CYCLES, 1024, consecutive stable cycles required to accept a new level; must be >=1.
- REPEAT_DELAY, 0, cycles from press pulse to first auto-repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 1, cycles between subsequent auto-repeat pulses; must be >=1.
- ACTIVE_LOW, 1, 1 = raw input low means pressed; input is inverted before the synchroniser.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  N_CH  raw asynchronous button inputs.
- level  output  N_CH  debounced pressed state, 1 = pressed.
- press  output  N_CH  one-cycle pulse on debounced 0->1.
- release  output  N_CH  one-cycle pulse on debounced 1->0.
- repeat  output  N_CH  pulse at press, then auto-repeat pulses while held.

Behaviour:
- Reset (synchronous): sync stages, debounce counters, level, press, release, repeat, repeat timers all 0; repeat FSM = IDLE. Takes effect at the first posedge with reset=1; outputs are 0 in the following cycle.
- Polarity: x = ACTIVE_LOW ? ~btn_in : btn_in. Synchroniser s1<=x, s2<=s1; s2 is the debounce input.
- Debounce, per channel, counter width $clog2(DEB_CYCLES+1):
  - If s2==level: counter<=0.
  - Else if counter==DEB_CYCLES-1: level<=s2, counter<=0.
  - Else: counter<=counter+1.
- Latency: clean step on btn_in. Counting the first posedge that samples the new value as edge 1, level changes at edge DEB_CYCLES+2.
- A disagreement shorter than DEB_CYCLES cycles at s2 causes no change and resets the counter.
- press and release are registered and asserted in exactly the cycle level first shows the new value, for one cycle. Never both in the same cycle on one channel.
- Repeat FSM, per channel, timer width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - IDLE: on debounced rise, repeat=1 (coincident with press), timer<=REPEAT_DELAY-1, go to WAIT. If REPEAT_DELAY==0, go to HELD instead.
  - WAIT: while level=1, count down. At timer==0, pulse repeat, timer<=REPEAT_PERIOD-1, go to RPT.
  - RPT: while level=1, count down. At timer==0, pulse repeat and reload REPEAT_PERIOD-1.
  - HELD: no further pulses.
  - Any state: debounced fall -> IDLE, timer cleared, no repeat pulse in that cycle.
- Auto-repeat pulse timing: first at P+REPEAT_DELAY, then every REPEAT_PERIOD, where P is the press cycle.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Reset mid-operation: all state cleared. An input still held after reset is released is treated as a new press after DEB_CYCLES+2 edges.
- Reset has priority over every other update.

Test Plan:
- Common config for all scenarios: N_CH=2, DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_LOW=0.
- Reset: hold reset 3 cycles with btn_in=2'b11 -> all outputs 0 during reset. After release, level[1:0]=11 at edge 6, press=11 for one cycle.
- Clean step: ch0 0->1 -> level[0] rises at edge 6, press[0] and repeat[0] high only at edge 6, ch1 outputs stay 0. Drop ch0 -> release[0] pulse 6 edges later.
- Glitch rejection: ch0 high for 3 cycles then low -> level, press, release stay 0. High for exactly 4 cycles -> level rises.
- Bounce: ch0 toggles every cycle for 20 cycles, then stays high -> exactly one press pulse, 6 edges after the final transition.
- Auto-repeat: hold ch0 for 30 cycles after press at cycle P -> repeat pulses at P, P+10, P+13, P+16, P+19, ... Release mid-period -> no further repeat, release pulse, FSM in IDLE.
- Reset and options:
  - Assert reset while ch0 is in RPT -> repeat and level 0 next cycle.
  - With REPEAT_DELAY=0 -> only the press-coincident repeat pulse.
  - With ACTIVE_LOW=1 -> btn_in=0 is reported as pressed.

Source files
------------

// File: rtl/btn_conditioner.sv
// btn_conditioner: multi-channel push-button front end.
// Each channel goes through polarity correction, a 2-FF synchroniser,
// a counter-based debouncer, registered press/release pulses and a
// hold-to-repeat state machine.
// "release" and "repeat" are reserved words in SystemVerilog, so those
// outputs are named release_pulse and repeat_pulse.
module btn_conditioner #(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 1024,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  localparam int CW   = $clog2(DEB_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0]   DEB_LAST    = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0]   DELAY_LOAD  = (REPEAT_DELAY > 0) ? TW'(REPEAT_DELAY - 1) : '0;
  localparam logic [TW-1:0]   PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);
  localparam bit              USE_REPEAT  = (REPEAT_DELAY > 0);
  localparam logic [N_CH-1:0] INV_MASK    = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RPT,
    S_HELD
  } rpt_state_t;

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;

  // Normalise polarity so 1 means pressed, then synchronise into clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in ^ INV_MASK;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          lvl;
    logic          prs;
    logic          rls;
    logic          commit;
    logic          rise;
    logic          fall;
    rpt_state_t    state;
    logic [TW-1:0] timer;
    logic          rpt;

    // commit marks the cycle in which the debounced level takes s2's value.
    assign commit = (s2[i] != lvl) && (cnt == DEB_LAST);
    assign rise   = commit & s2[i];
    assign fall   = commit & ~s2[i];

    // Debounce: s2 must disagree with level for DEB_CYCLES cycles in a row;
    // press/release pulse in the same cycle the new level appears.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rls <= 1'b0;
      end else begin
        prs <= 1'b0;
        rls <= 1'b0;
        if (s2[i] == lvl) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          lvl <= s2[i];
          cnt <= '0;
          prs <= s2[i];
          rls <= ~s2[i];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    // Auto-repeat: pulse with the press, then after REPEAT_DELAY and every
    // REPEAT_PERIOD while held; a debounced fall always returns to idle.
    always_ff @(posedge clk) begin
      if (reset) begin
        state <= S_IDLE;
        timer <= '0;
        rpt   <= 1'b0;
      end else begin
        rpt <= 1'b0;
        if (fall) begin
          state <= S_IDLE;
          timer <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              if (rise) begin
                rpt <= 1'b1;
                if (USE_REPEAT) begin
                  timer <= DELAY_LOAD;
                  state <= S_WAIT;
                end else begin
                  state <= S_HELD;
                end
              end
            end
            S_WAIT: begin
              if (lvl) begin
                if (timer == '0) begin
                  rpt   <= 1'b1;
                  timer <= PERIOD_LOAD;
                  state <= S_RPT;
                end else begin
                  timer <= timer - TW'(1);
                end
              end
            end
            S_RPT: begin
              if (lvl) begin
                if (timer == '0) begin
                  rpt   <= 1'b1;
                  timer <= PERIOD_LOAD;
                end else begin
                  timer <= timer - TW'(1);
                end
              end
            end
            S_HELD: begin
              state <= S_HELD;
            end
            default: begin
              state <= S_IDLE;
              timer <= '0;
            end
          endcase
        end
      end
    end

    assign level[i]         = lvl;
    assign press[i]         = prs;
    assign release_pulse[i] = rls;
    assign repeat_pulse[i]  = rpt;
  end

endmodule
